// File: rtl/simd_pkg.sv
// Shared types and defaults for the SIMD operand-issue / writeback stage.
package simd_pkg;

    localparam int SIMD_NREGS = 8;
    localparam int SIMD_AW    = 3;

    typedef enum logic [1:0] {
        W8   = 2'b00,
        W16  = 2'b01,
        W32  = 2'b10,
        WRSV = 2'b11
    } width_e;

    typedef struct packed {
        logic [SIMD_AW-1:0] rs1;
        logic [SIMD_AW-1:0] rs2;
        logic [SIMD_AW-1:0] rd;
        width_e             width;
        logic               saturate;
    } cmd_t;

    function automatic logic is_rsv(input logic [1:0] w);
        return w == WRSV;
    endfunction

endpackage

// File: rtl/simd_regfile.sv
// SIMD register file: NREGS x 32, two combinational reads, retire write beats host write.
module simd_regfile
    import simd_pkg::*;
#(
    parameter int NREGS = SIMD_NREGS,
    parameter int AW    = SIMD_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] rd_addr_a,
    input  logic [AW-1:0] rd_addr_b,
    output logic [31:0]   rd_data_a,
    output logic [31:0]   rd_data_b,
    input  logic          ret_we,
    input  logic [AW-1:0] ret_addr,
    input  logic [31:0]   ret_data,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [31:0]   host_data
);

    logic [NREGS-1:0][31:0] regs;

    // Retire and host may both write in one cycle; only a shared address needs arbitration.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                if (ret_we && ret_addr == AW'(i))
                    regs[i] <= ret_data;
                else if (host_we && host_addr == AW'(i))
                    regs[i] <= host_data;
            end
        end
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/simd_issue_stage.sv
// Operand issue + writeback around the external packed SIMD adder.
// SIMD_BYPASS_EN: forward the retiring ALU result; otherwise stall one cycle on a hazard.
module simd_issue_stage
    import simd_pkg::*;
#(
    parameter int NREGS = SIMD_NREGS,
    parameter int AW    = SIMD_AW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [AW-1:0] cmd_rs1,
    input  logic [AW-1:0] cmd_rs2,
    input  logic [AW-1:0] cmd_rd,
    input  logic [1:0]    cmd_width,
    input  logic          cmd_saturate,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    output logic [31:0]   alu_a,
    output logic [31:0]   alu_b,
    output logic [1:0]    alu_width,
    output logic          alu_saturate,
    input  logic [31:0]   alu_c,
    output logic          res_valid,
    output logic [AW-1:0] res_rd,
    output logic [31:0]   res_data,
    output logic          err
);

    cmd_t          cmd;
    logic          ex_valid;
    logic [AW-1:0] ex_rd;
    logic          retire;
    logic          fwd_a, fwd_b, hazard, accept;
    logic [31:0]   rf_a, rf_b, op_a, op_b;

    assign cmd = '{rs1: cmd_rs1, rs2: cmd_rs2, rd: cmd_rd,
                   width: width_e'(cmd_width), saturate: cmd_saturate};

    // A reserved-width op in EX never writes back, so it is neither forwarded nor a hazard.
    assign retire = ex_valid & ~is_rsv(alu_width);

`ifdef SIMD_BYPASS_EN
    assign fwd_a  = retire & (cmd.rs1 == ex_rd);
    assign fwd_b  = retire & (cmd.rs2 == ex_rd);
    assign hazard = 1'b0;
`else
    assign fwd_a  = 1'b0;
    assign fwd_b  = 1'b0;
    assign hazard = retire & ((cmd.rs1 == ex_rd) | (cmd.rs2 == ex_rd));
`endif

    assign cmd_ready = ~wr_en & ~hazard;
    assign accept    = cmd_valid & cmd_ready;
    assign op_a      = fwd_a ? alu_c : rf_a;
    assign op_b      = fwd_b ? alu_c : rf_b;

    simd_regfile #(.NREGS(NREGS), .AW(AW)) u_rf (
        .clk       (clk),
        .rst       (rst),
        .rd_addr_a (cmd.rs1),
        .rd_addr_b (cmd.rs2),
        .rd_data_a (rf_a),
        .rd_data_b (rf_b),
        .ret_we    (retire),
        .ret_addr  (ex_rd),
        .ret_data  (alu_c),
        .host_we   (wr_en),
        .host_addr (wr_addr),
        .host_data (wr_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_rd        <= '0;
            alu_a        <= '0;
            alu_b        <= '0;
            alu_width    <= '0;
            alu_saturate <= 1'b0;
            res_valid    <= 1'b0;
            res_rd       <= '0;
            res_data     <= '0;
            err          <= 1'b0;
        end else begin
            ex_valid  <= accept;
            res_valid <= retire;
            err       <= ex_valid & is_rsv(alu_width);
            if (accept) begin
                alu_a        <= op_a;
                alu_b        <= op_b;
                alu_width    <= cmd.width;
                alu_saturate <= cmd.saturate;
                ex_rd        <= cmd.rd;
            end
            if (retire) begin
                res_rd   <= ex_rd;
                res_data <= alu_c;
            end
        end
    end

endmodule

// File: tb/tb_simd_issue_stage.sv
// Randomized self-checking bench for simd_issue_stage against an in-order architectural model.
module tb_simd_issue_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [2:0]  cmd_rs1, cmd_rs2, cmd_rd;
    logic [1:0]  cmd_width;
    logic        cmd_saturate;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] alu_a, alu_b, alu_c;
    logic [1:0]  alu_width;
    logic        alu_saturate;
    logic        res_valid;
    logic [2:0]  res_rd;
    logic [31:0] res_data;
    logic        err;

    always #5 clk = ~clk;

    simd_issue_stage dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_rd(cmd_rd),
        .cmd_width(cmd_width), .cmd_saturate(cmd_saturate),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .alu_a(alu_a), .alu_b(alu_b), .alu_width(alu_width), .alu_saturate(alu_saturate),
        .alu_c(alu_c),
        .res_valid(res_valid), .res_rd(res_rd), .res_data(res_data), .err(err)
    );

    // Lane-wise signed add with optional clamping; stands in for the downstream ALU.
    function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                          input logic [1:0] w, input logic s);
        int          lw;
        longint      x, y, sum, hi, lo;
        logic [31:0] r;
        lw = (w == 2'b00) ? 8 : (w == 2'b01) ? 16 : 32;
        hi = (longint'(1) <<< (lw - 1)) - 1;
        lo = -hi - 1;
        r  = '0;
        for (int l = 0; l < 32 / lw; l++) begin
            x = longint'((64'(a) >> (l * lw)) & ((64'd1 << lw) - 1));
            y = longint'((64'(b) >> (l * lw)) & ((64'd1 << lw) - 1));
            if (x > hi) x -= longint'(1) <<< lw;
            if (y > hi) y -= longint'(1) <<< lw;
            sum = x + y;
            if (s) begin
                if (sum > hi) sum = hi;
                else if (sum < lo) sum = lo;
            end
            for (int k = 0; k < lw; k++) r[l * lw + k] = sum[k];
        end
        return r;
    endfunction

    assign alu_c = alu_f(alu_a, alu_b, alu_width, alu_saturate);

    typedef struct packed {
        logic        v, e;
        logic [2:0]  rd;
        logic [31:0] d, a, b;
        logic [1:0]  w;
        logic        s;
    } pend_t;

`ifdef SIMD_BYPASS_EN
    localparam int EXP_STALLS = 0;
`else
    localparam int EXP_STALLS = 1;
`endif

    logic [31:0] rf_m [8];
    pend_t       pend;
    logic [31:0] last_res;
    int          stalls;
    int          checks = 0;
    int          failures = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h @%0t", tag, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, check ready, update model at the edge, check outputs after it.
    task automatic step(input logic v, input logic [2:0] rs1, input logic [2:0] rs2,
                        input logic [2:0] rd, input logic [1:0] w, input logic s,
                        input logic we, input logic [2:0] wa, input logic [31:0] wd,
                        output logic acc);
        logic  er;
        pend_t nxt;
        @(negedge clk);
        cmd_valid = v; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_rd = rd;
        cmd_width = w; cmd_saturate = s;
        wr_en = we; wr_addr = wa; wr_data = wd;
        er = !we;
`ifndef SIMD_BYPASS_EN
        if (pend.v && !pend.e && (rs1 == pend.rd || rs2 == pend.rd)) er = 1'b0;
`endif
        #1 check("cmd_ready", 32'(cmd_ready), 32'(er));
        acc = v && er;
        nxt = '0;
        if (acc) begin
            nxt.v = 1'b1; nxt.e = (w == 2'b11); nxt.rd = rd;
            nxt.a = rf_m[rs1]; nxt.b = rf_m[rs2]; nxt.w = w; nxt.s = s;
            nxt.d = alu_f(nxt.a, nxt.b, w, s);
        end
        @(posedge clk);
        // Commands take effect in order; a host write colliding with the retiring command is lost.
        if (we && !(pend.v && !pend.e && pend.rd == wa)) rf_m[wa] = wd;
        if (nxt.v && !nxt.e) rf_m[rd] = nxt.d;
        #1;
        check("res_valid", 32'(res_valid), 32'(pend.v && !pend.e));
        check("err", 32'(err), 32'(pend.v && pend.e));
        if (pend.v && !pend.e) begin
            check("res_rd", 32'(res_rd), 32'(pend.rd));
            check("res_data", res_data, pend.d);
            last_res = res_data;
        end
        if (nxt.v) begin
            check("alu_a", alu_a, nxt.a);
            check("alu_b", alu_b, nxt.b);
            check("alu_width", 32'(alu_width), 32'(nxt.w));
            check("alu_saturate", 32'(alu_saturate), 32'(nxt.s));
        end
        pend = nxt;
    endtask

    task automatic issue(input logic [2:0] rs1, input logic [2:0] rs2, input logic [2:0] rd,
                         input logic [1:0] w, input logic s);
        logic acc;
        int   n = 0;
        do begin
            step(1'b1, rs1, rs2, rd, w, s, 1'b0, 3'd0, 32'd0, acc);
            n++;
        end while (!acc && n < 4);
        check("issue_accept", 32'(acc), 32'd1);
        stalls = n - 1;
    endtask

    task automatic idle();
        logic acc;
        step(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b0, 3'd0, 32'd0, acc);
    endtask

    task automatic host(input logic [2:0] wa, input logic [31:0] wd);
        logic acc;
        step(1'b0, 3'd0, 3'd0, 3'd0, 2'b00, 1'b0, 1'b1, wa, wd, acc);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_alu_a"}, alu_a, 32'd0);
        check({tag, "_alu_b"}, alu_b, 32'd0);
        check({tag, "_alu_width"}, 32'(alu_width), 32'd0);
        check({tag, "_alu_sat"}, 32'(alu_saturate), 32'd0);
        check({tag, "_res_valid"}, 32'(res_valid), 32'd0);
        check({tag, "_res_rd"}, 32'(res_rd), 32'd0);
        check({tag, "_res_data"}, res_data, 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    initial begin
        logic acc;
        rst = 1'b1;
        cmd_valid = 0; cmd_rs1 = 0; cmd_rs2 = 0; cmd_rd = 0; cmd_width = 0; cmd_saturate = 0;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        pend = '0;
        last_res = '0;
        stalls = 0;
        repeat (2) @(posedge clk);
        #1 check_zero_outputs("reset");
        @(negedge clk) rst = 1'b0;

        // Saturating and wrapping adds on the same operands.
        host(3'd1, 32'h7F7F7F7F);
        host(3'd2, 32'h01010101);
        issue(3'd1, 3'd2, 3'd3, 2'b00, 1'b1);
        idle();
        check("sat8", last_res, 32'h7F7F7F7F);
        issue(3'd3, 3'd0, 3'd6, 2'b10, 1'b0);
        idle();
        check("rf3_readback", last_res, 32'h7F7F7F7F);
        issue(3'd1, 3'd2, 3'd6, 2'b00, 1'b0);
        idle();
        check("wrap8", last_res, 32'h80808080);
        issue(3'd1, 3'd2, 3'd6, 2'b10, 1'b0);
        idle();
        check("add32", last_res, 32'h80808080);

        // Back-to-back dependency.
        issue(3'd1, 3'd2, 3'd3, 2'b10, 1'b0);
        issue(3'd3, 3'd2, 3'd4, 2'b10, 1'b0);
        check("dep_stalls", 32'(stalls), 32'(EXP_STALLS));
        idle();
        check("dep_result", last_res, 32'h81818181);

        // Reserved width: err pulse, no writeback, dependent op sees the old value.
        host(3'd7, 32'h12345678);
        issue(3'd1, 3'd2, 3'd7, 2'b11, 1'b0);
        issue(3'd7, 3'd0, 3'd6, 2'b10, 1'b0);
        check("rsv_stalls", 32'(stalls), 32'd0);
        idle();
        check("rsv_old_value", last_res, 32'h12345678);

        // Host write collides with a retire to the same register.
        issue(3'd1, 3'd2, 3'd5, 2'b10, 1'b0);
        step(1'b1, 3'd0, 3'd5, 3'd6, 2'b10, 1'b0, 1'b1, 3'd5, 32'hDEADBEEF, acc);
        check("collide_no_accept", 32'(acc), 32'd0);
        issue(3'd0, 3'd5, 3'd6, 2'b10, 1'b0);
        idle();
        check("collide_retire_wins", last_res, 32'h80808080);

        // rs1 == rs2 == rd.
        issue(3'd2, 3'd2, 3'd2, 2'b00, 1'b0);
        issue(3'd2, 3'd2, 3'd2, 2'b00, 1'b0);
        idle();
        check("self_dep", last_res, 32'h04040404);

        // Asynchronous reset while a command sits in EX.
        issue(3'd1, 3'd1, 3'd6, 2'b10, 1'b0);
        #2 rst = 1'b1;
        #1 check_zero_outputs("async_rst");
        for (int i = 0; i < 8; i++) rf_m[i] = '0;
        pend = '0;
        @(posedge clk);
        #1 check("rst_no_retire", 32'(res_valid), 32'd0);
        @(negedge clk) rst = 1'b0;
        cmd_valid = 0; wr_en = 0;
        issue(3'd1, 3'd2, 3'd3, 2'b10, 1'b0);
        idle();
        check("rf_cleared", last_res, 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0,
                 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                 $urandom_range(0, 4) == 0, 3'($urandom_range(0, 7)), 32'($urandom()), acc);
        end
        idle();
        idle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/simd_issue_stage.md
Name: simd_issue_stage

Overview:
- Operand-issue and writeback stage directly upstream of the packed SIMD adder (`alu`: 8/16/32-bit lanes, optional saturation).
- Holds the SIMD register file and accepts register-addressed commands over valid/ready.
- Registers operands, width and saturate into the combinational ALU, then writes the ALU result back to the register file one cycle later.
- Includes a result-forwarding path for back-to-back dependent commands.

Parameters:
- NREGS, 8: number of 32-bit SIMD registers (power of two, ≥2).
- AW, 3: register address width, equal to log2(NREGS).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  stage can accept a command this cycle.
- cmd_rs1, cmd_rs2, cmd_rd  in  AW each  source and destination registers.
- cmd_width  in  2  lane width: 00=8b, 01=16b, 10=32b, 11=reserved.
- cmd_saturate  in  1  saturating add.
- wr_en, wr_addr(AW), wr_data(32)  in  host register-load port.
- alu_a, alu_b  out  32 each  registered operands to the ALU.
- alu_width  out  2  registered to the ALU.
- alu_saturate  out  1  registered to the ALU.
- alu_c  in  32  combinational ALU result.
- res_valid  out  1  one-cycle pulse, result retired.
- res_rd  out  AW  destination of the retired result.
- res_data  out  32  retired result.
- err  out  1  one-cycle pulse, reserved width retired.

Behaviour:
- Reset (async, rst=1): all registers cleared to 0. alu_a, alu_b, alu_width, alu_saturate, res_* and err are 0. ex_valid=0. Takes effect immediately; any in-flight command is discarded with no writeback.
- Two stages:
  - ISSUE: command accepted when cmd_valid & cmd_ready.
  - EX: ex_valid, ex_rd and ALU inputs are registered.
- Accept at edge N: alu_a=RF[rs1], alu_b=RF[rs2] (after forwarding), alu_width, alu_saturate and ex_rd are loaded; ex_valid=1.
- During cycle N+1 the ALU drives alu_c.
- Edge N+1 (retire): if ex_valid and width≠11, RF[ex_rd]<=alu_c, res_valid=1, res_data=alu_c, res_rd=ex_rd.
  - If width=11: no writeback, err=1, res_valid=0.
- Result latency: accept to res_valid = 2 edges.
- Throughput: one command per cycle.
- Edge with no accept: ex_valid<=0; alu_* outputs hold their last values.
- cmd_ready = ~wr_en (host load has priority; no issue in a host-write cycle).
- Forwarding: if ex_valid and width≠11 and rs1==ex_rd, the stage uses alu_c instead of RF[rs1]. Same rule for rs2.
- Simultaneous host write and retire to the same address: retire wins.
- Host write to a different address: both take effect.
- Reading a register being host-written is impossible, because cmd_ready=0 in that cycle.
- rs1==rs2==rd is legal; forwarding applies to both operands.

Optional Feature:
- SIMD_BYPASS_EN defined: forwarding as above; no hazard stalls.
- SIMD_BYPASS_EN undefined: no forwarding path.
  - cmd_ready = ~wr_en & ~(ex_valid & ex_width≠11 & (cmd_rs1==ex_rd | cmd_rs2==ex_rd)).
  - A dependent command stalls exactly one cycle, then reads the written-back value from the RF.

Decomposition:
- Package simd_pkg:
  - Width encodings: W8=2'b00, W16=2'b01, W32=2'b10, WRSV=2'b11.
  - NREGS/AW defaults.
  - Packed command struct {rs1, rs2, rd, width, saturate}.
- One sub-module, simd_regfile:
  - NREGS×32, two combinational read ports.
  - One write port with priority mux (retire over host).
  - Async reset to zero.
- Forwarding/hazard logic and EX registers stay in the top level.

Test Plan:
- Reset, then host-load r1=0x7F7F7F7F, r2=0x01010101. Issue rd=3, width=00, sat=1 → 2 edges later res_valid=1, res_rd=3, res_data=0x7F7F7F7F; RF[3]=0x7F7F7F7F.
- Same operands, width=00, sat=0 → res_data=0x80808080. Then width=10, sat=0 → 0x80808080.
- Back-to-back r3=r1+r2 (width=10, sat=0, expect 0x80808080) then r4=r3+r2 on the next cycle, bypass on → cmd_ready stays 1; second res_data=0x81818181.
  - Bypass off: cmd_ready=0 for exactly one cycle, same final value.
- Issue with width=11 → err pulses at retire, res_valid=0, RF[rd] unchanged. A dependent next command is not forwarded and reads the old RF value.
- Host wr_en to r5 in the same cycle a retire targets r5 → RF[5]=alu_c. cmd_ready=0 in that cycle.
- Assert rst asynchronously with ex_valid=1 → no writeback, res_valid=0, all outputs 0 before the next clk edge.
